// File: rtl/lsb_queue_pkg.sv
// Shared definitions for the load/store buffer: op codes, FSM states,
// default geometry and the op-to-access-width mapping.
package lsb_queue_pkg;

  localparam int              XLEN_DEF      = 32;
  localparam logic [31:0]     IO_BASE_DEF   = 32'h0003_0000;
  localparam int              NON_DEPENDENT = 0;

  // Bit 3 marks a store, bit 2 marks an unsigned load, bits 1:0 give the size.
  typedef enum logic [3:0] {
    OP_LB  = 4'h0,
    OP_LH  = 4'h1,
    OP_LW  = 4'h2,
    OP_LBU = 4'h4,
    OP_LHU = 4'h5,
    OP_SB  = 4'h8,
    OP_SH  = 4'h9,
    OP_SW  = 4'hA
  } lsb_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_MEM,
    ST_DRAIN
  } lsb_state_e;

  // Size field of the op code -> access width in bytes.
  function automatic logic [2:0] lsb_width_bytes(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsb_queue_load_ext.sv
// Combinational load-result extension: picks the loaded byte/half/word out
// of the raw memory word and sign- or zero-extends it to XLEN.
module lsb_load_ext
  import lsb_queue_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] result
);

  // Extension selected by the load flavour; words pass straight through.
  always_comb begin
    result = raw;
    case (op)
      OP_LB:   result = {{(XLEN-8){raw[7]}}, raw[7:0]};
      OP_LH:   result = {{(XLEN-16){raw[15]}}, raw[15:0]};
      OP_LBU:  result = {{(XLEN-8){1'b0}}, raw[7:0]};
      OP_LHU:  result = {{(XLEN-16){1'b0}}, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/lsb_queue.sv
// Load/store buffer: circular queue issuing memory ops in program order from
// the head. Non-IO loads issue speculatively, IO loads wait for the ROB head,
// stores wait for commit. A flush keeps committed entries and drains an
// in-flight speculative load without broadcasting it.
// Optional macro LSB_PERF_CNT_EN adds saturating performance counters.
module lsb_queue
  import lsb_queue_pkg::*;
#(
  parameter int              LSB_DEPTH = 16,
  parameter int              ROB_ID_W  = 5,
  parameter int              XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] IO_BASE   = IO_BASE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                dsp_en,
  input  logic [XLEN-1:0]     dsp_vj,
  input  logic [XLEN-1:0]     dsp_vk,
  input  logic [XLEN-1:0]     dsp_imm,
  input  logic [ROB_ID_W-1:0] dsp_qj,
  input  logic [ROB_ID_W-1:0] dsp_qk,
  input  logic [ROB_ID_W-1:0] dsp_rob_id,
  input  logic [3:0]          dsp_type,
  input  logic                cdb_rs_en,
  input  logic [ROB_ID_W-1:0] cdb_rs_id,
  input  logic [XLEN-1:0]     cdb_rs_val,
  output logic                cdb_lsb_en,
  output logic [ROB_ID_W-1:0] cdb_lsb_id,
  output logic [XLEN-1:0]     cdb_lsb_val,
  output logic                mem_en,
  output logic                mem_we,
  output logic [XLEN-1:0]     mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [2:0]          mem_width,
  input  logic                mem_ok,
  input  logic [XLEN-1:0]     mem_rdata,
  input  logic                commit_en,
  input  logic [ROB_ID_W-1:0] commit_rob_id,
  input  logic [ROB_ID_W-1:0] rob_head_id,
  input  logic                flush,
  output logic                full
`ifdef LSB_PERF_CNT_EN
  ,
  output logic [31:0]         perf_loads,
  output logic [31:0]         perf_stores,
  output logic [31:0]         perf_wait_cycles
`endif
);

  localparam int PTR_W = $clog2(LSB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ROB_ID_W-1:0] ND = ROB_ID_W'(NON_DEPENDENT);

  typedef struct packed {
    logic                busy;
    logic                committed;
    logic [3:0]          op;
    logic [XLEN-1:0]     vj;
    logic [XLEN-1:0]     vk;
    logic [XLEN-1:0]     imm;
    logic [ROB_ID_W-1:0] qj;
    logic [ROB_ID_W-1:0] qk;
    logic [ROB_ID_W-1:0] rob_id;
  } entry_t;

  entry_t              ent_q [LSB_DEPTH];
  entry_t              ent_d [LSB_DEPTH];
  logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  lsb_state_e          state_q, state_d;
  logic                mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [XLEN-1:0]     mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [2:0]          mem_width_q, mem_width_d;
  logic                cdb_lsb_en_q, cdb_lsb_en_d;
  logic [ROB_ID_W-1:0] cdb_lsb_id_q, cdb_lsb_id_d;
  logic [XLEN-1:0]     cdb_lsb_val_q, cdb_lsb_val_d;

  entry_t              head_ent, dsp_ent;
  logic [XLEN-1:0]     head_addr, load_result;
  logic                head_store, head_io, head_ready, head_commit_now, head_go;
  logic                issue, push, pop;
  logic [CNT_W-1:0]    occ, busy_cnt;
  logic [PTR_W-1:0]    tail_scan, idx;

  lsb_load_ext #(.XLEN(XLEN)) u_load_ext (
    .op     (head_ent.op),
    .raw    (mem_rdata),
    .result (load_result)
  );

  // Head-entry decode: address, class and whether it may issue now.
  always_comb begin
    head_ent        = ent_q[head_q];
    head_addr       = head_ent.vj + head_ent.imm;
    head_store      = head_ent.op[3];
    head_io         = (head_addr >= IO_BASE);
    head_ready      = head_ent.busy && (head_ent.qj == ND) &&
                      (!head_store || (head_ent.qk == ND));
    head_commit_now = head_ent.committed ||
                      (commit_en && !flush && (commit_rob_id == head_ent.rob_id));
    head_go         = head_store ? head_commit_now
                                 : (!head_io || (rob_head_id == head_ent.rob_id));
  end

  // Queue update: wakeup, commit, FSM, dispatch, then flush overrides.
  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    state_d       = state_q;
    mem_en_d      = mem_en_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_width_d   = mem_width_q;
    cdb_lsb_en_d  = 1'b0;
    cdb_lsb_id_d  = cdb_lsb_id_q;
    cdb_lsb_val_d = cdb_lsb_val_q;
    issue         = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    dsp_ent       = '0;
    occ           = '0;
    busy_cnt      = '0;
    tail_scan     = '0;
    idx           = '0;
    for (int i = 0; i < LSB_DEPTH; i++) ent_d[i] = ent_q[i];

    for (int i = 0; i < LSB_DEPTH; i++) begin
      if (ent_q[i].busy) begin
        if (ent_q[i].qj != ND) begin
          if (cdb_rs_en && cdb_rs_id == ent_q[i].qj) begin
            ent_d[i].vj = cdb_rs_val;
            ent_d[i].qj = ND;
          end else if (cdb_lsb_en_q && cdb_lsb_id_q == ent_q[i].qj) begin
            ent_d[i].vj = cdb_lsb_val_q;
            ent_d[i].qj = ND;
          end
        end
        if (ent_q[i].qk != ND) begin
          if (cdb_rs_en && cdb_rs_id == ent_q[i].qk) begin
            ent_d[i].vk = cdb_rs_val;
            ent_d[i].qk = ND;
          end else if (cdb_lsb_en_q && cdb_lsb_id_q == ent_q[i].qk) begin
            ent_d[i].vk = cdb_lsb_val_q;
            ent_d[i].qk = ND;
          end
        end
        if (commit_en && !flush && commit_rob_id == ent_q[i].rob_id)
          ent_d[i].committed = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (head_ready) begin
          if (head_go) issue = 1'b1;
          else         state_d = ST_WAIT;
        end else if (!head_ent.busy && head_q != tail_q) begin
          // Skip a slot vacated by a flush.
          head_d = head_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (head_ready && head_go) issue = 1'b1;
      end
      ST_MEM: begin
        if (mem_ok) begin
          mem_en_d                 = 1'b0;
          state_d                  = ST_IDLE;
          ent_d[head_q].busy       = 1'b0;
          ent_d[head_q].committed  = 1'b0;
          head_d                   = head_q + 1'b1;
          pop                      = 1'b1;
          if (!head_store) begin
            cdb_lsb_en_d  = 1'b1;
            cdb_lsb_id_d  = head_ent.rob_id;
            cdb_lsb_val_d = load_result;
          end
        end
      end
      ST_DRAIN: begin
        if (mem_ok) begin
          mem_en_d = 1'b0;
          state_d  = ST_IDLE;
          head_d   = head_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (issue) begin
      state_d     = ST_MEM;
      mem_en_d    = 1'b1;
      mem_we_d    = head_store;
      mem_addr_d  = head_addr;
      mem_wdata_d = head_ent.vk;
      mem_width_d = lsb_width_bytes(head_ent.op[1:0]);
    end

    if (dsp_en && !flush && count_q < CNT_W'(LSB_DEPTH)) begin
      dsp_ent.busy   = 1'b1;
      dsp_ent.op     = dsp_type;
      dsp_ent.vj     = dsp_vj;
      dsp_ent.vk     = dsp_vk;
      dsp_ent.imm    = dsp_imm;
      dsp_ent.qj     = dsp_qj;
      dsp_ent.qk     = dsp_qk;
      dsp_ent.rob_id = dsp_rob_id;
      if (dsp_qj != ND) begin
        if (cdb_rs_en && cdb_rs_id == dsp_qj) begin
          dsp_ent.vj = cdb_rs_val;
          dsp_ent.qj = ND;
        end else if (cdb_lsb_en_q && cdb_lsb_id_q == dsp_qj) begin
          dsp_ent.vj = cdb_lsb_val_q;
          dsp_ent.qj = ND;
        end
      end
      if (dsp_qk != ND) begin
        if (cdb_rs_en && cdb_rs_id == dsp_qk) begin
          dsp_ent.vk = cdb_rs_val;
          dsp_ent.qk = ND;
        end else if (cdb_lsb_en_q && cdb_lsb_id_q == dsp_qk) begin
          dsp_ent.vk = cdb_lsb_val_q;
          dsp_ent.qk = ND;
        end
      end
      ent_d[tail_q] = dsp_ent;
      tail_d        = tail_q + 1'b1;
      push          = 1'b1;
    end

    count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

    if (flush) begin
      cdb_lsb_en_d = 1'b0;
      for (int i = 0; i < LSB_DEPTH; i++)
        if (!ent_d[i].committed) ent_d[i].busy = 1'b0;

      // A speculative load already on the bus must finish its handshake.
      if (state_q == ST_MEM && !mem_ok && !head_store && !head_ent.committed)
        state_d = ST_DRAIN;
      // Anything uncommitted about to issue from IDLE/WAIT is cancelled.
      if ((state_q == ST_IDLE || state_q == ST_WAIT) && !head_ent.committed) begin
        state_d  = ST_IDLE;
        mem_en_d = 1'b0;
      end

      // New tail sits just past the youngest surviving entry.
      occ = (tail_q == head_q && count_q != '0) ? CNT_W'(LSB_DEPTH)
                                                : {1'b0, tail_q - head_q};
      tail_scan = (state_d == ST_DRAIN) ? head_q + 1'b1 : head_d;
      for (int i = 0; i < LSB_DEPTH; i++) begin
        idx = head_q + PTR_W'(i);
        if (CNT_W'(i) < occ && ent_d[idx].busy) tail_scan = idx + 1'b1;
        busy_cnt = busy_cnt + {{PTR_W{1'b0}}, ent_d[i].busy};
      end
      tail_d  = tail_scan;
      count_d = busy_cnt;
    end
  end

  // State registers; rdy low freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LSB_DEPTH; i++) ent_q[i] <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      state_q       <= ST_IDLE;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_width_q   <= '0;
      cdb_lsb_en_q  <= 1'b0;
      cdb_lsb_id_q  <= '0;
      cdb_lsb_val_q <= '0;
    end else if (rdy) begin
      for (int i = 0; i < LSB_DEPTH; i++) ent_q[i] <= ent_d[i];
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      state_q       <= state_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_width_q   <= mem_width_d;
      cdb_lsb_en_q  <= cdb_lsb_en_d;
      cdb_lsb_id_q  <= cdb_lsb_id_d;
      cdb_lsb_val_q <= cdb_lsb_val_d;
    end
  end

  assign full        = (count_q >= CNT_W'(LSB_DEPTH - 1));
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_width   = mem_width_q;
  assign cdb_lsb_en  = cdb_lsb_en_q;
  assign cdb_lsb_id  = cdb_lsb_id_q;
  assign cdb_lsb_val = cdb_lsb_val_q;

`ifdef LSB_PERF_CNT_EN
  logic [31:0] perf_loads_q, perf_loads_d;
  logic [31:0] perf_stores_q, perf_stores_d;
  logic [31:0] perf_wait_q, perf_wait_d;

  // Saturating counters; a drained load never raises cdb_lsb_en_d.
  always_comb begin
    perf_loads_d  = perf_loads_q;
    perf_stores_d = perf_stores_q;
    perf_wait_d   = perf_wait_q;
    if (cdb_lsb_en_d && perf_loads_q != '1) perf_loads_d = perf_loads_q + 1'b1;
    if (state_q == ST_MEM && mem_ok && head_store && perf_stores_q != '1)
      perf_stores_d = perf_stores_q + 1'b1;
    if (state_q == ST_WAIT && perf_wait_q != '1) perf_wait_d = perf_wait_q + 1'b1;
  end

  // Counter registers, frozen with the rest of the queue when rdy is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_loads_q  <= '0;
      perf_stores_q <= '0;
      perf_wait_q   <= '0;
    end else if (rdy) begin
      perf_loads_q  <= perf_loads_d;
      perf_stores_q <= perf_stores_d;
      perf_wait_q   <= perf_wait_d;
    end
  end

  assign perf_loads       = perf_loads_q;
  assign perf_stores      = perf_stores_q;
  assign perf_wait_cycles = perf_wait_q;
`endif

endmodule

// File: tb/tb_lsb_queue.sv
// Directed bench for lsb_queue: a table of single-op vectors plus hand
// sequences for IO wait, CDB bypass/wakeup, full/wrap, flush and reset.
module tb_lsb_queue;

  logic        clk = 1'b0;
  logic        rst, rdy, dsp_en, cdb_rs_en, mem_ok, commit_en, flush;
  logic [31:0] dsp_vj, dsp_vk, dsp_imm, cdb_rs_val, mem_rdata;
  logic [4:0]  dsp_qj, dsp_qk, dsp_rob_id, cdb_rs_id, commit_rob_id, rob_head_id;
  logic [3:0]  dsp_type;
  logic        cdb_lsb_en, mem_en, mem_we, full;
  logic [4:0]  cdb_lsb_id;
  logic [31:0] cdb_lsb_val, mem_addr, mem_wdata;
  logic [2:0]  mem_width;
`ifdef LSB_PERF_CNT_EN
  logic [31:0] perf_loads, perf_stores, perf_wait_cycles;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsb_queue dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .dsp_en(dsp_en), .dsp_vj(dsp_vj), .dsp_vk(dsp_vk), .dsp_imm(dsp_imm),
    .dsp_qj(dsp_qj), .dsp_qk(dsp_qk), .dsp_rob_id(dsp_rob_id), .dsp_type(dsp_type),
    .cdb_rs_en(cdb_rs_en), .cdb_rs_id(cdb_rs_id), .cdb_rs_val(cdb_rs_val),
    .cdb_lsb_en(cdb_lsb_en), .cdb_lsb_id(cdb_lsb_id), .cdb_lsb_val(cdb_lsb_val),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_width(mem_width), .mem_ok(mem_ok), .mem_rdata(mem_rdata),
    .commit_en(commit_en), .commit_rob_id(commit_rob_id), .rob_head_id(rob_head_id),
    .flush(flush), .full(full)
`ifdef LSB_PERF_CNT_EN
    , .perf_loads(perf_loads), .perf_stores(perf_stores),
    .perf_wait_cycles(perf_wait_cycles)
`endif
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] vj, imm, vk, rdata;
    logic [31:0] exp_addr;
    logic [2:0]  exp_width;
    logic [31:0] exp_val;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic dispatch(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                          input logic [31:0] imm, input logic [4:0] qj, input logic [4:0] rob);
    dsp_en = 1'b1; dsp_type = op; dsp_vj = vj; dsp_vk = vk; dsp_imm = imm;
    dsp_qj = qj; dsp_qk = 5'd0; dsp_rob_id = rob;
    tick();
    dsp_en = 1'b0;
    $display("dispatch op=%h addr=%h data=%h rob=%0d", op, vj + imm, vk, rob);
  endtask

  task automatic wait_mem(input string name);
    int n = 0;
    while (mem_en !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({name, "_issue"}, {31'd0, mem_en}, 32'd1);
  endtask

  task automatic complete(input logic [31:0] rdata);
    mem_ok = 1'b1; mem_rdata = rdata;
    tick();
    mem_ok = 1'b0; mem_rdata = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'hA, 32'h100,   32'h0,        32'h1234_5678, 32'h0,         32'h100,   3'd4, 32'h0};
    vecs[1] = '{4'h0, 32'h200,   32'h0,        32'h0,         32'h0000_0080, 32'h200,   3'd1, 32'hFFFF_FF80};
    vecs[2] = '{4'h4, 32'h200,   32'h0,        32'h0,         32'h0000_0080, 32'h200,   3'd1, 32'h0000_0080};
    vecs[3] = '{4'h1, 32'h1F0,   32'h10,       32'h0,         32'h0000_8001, 32'h200,   3'd2, 32'hFFFF_8001};
    vecs[4] = '{4'h5, 32'h1F0,   32'h10,       32'h0,         32'h0000_8001, 32'h200,   3'd2, 32'h0000_8001};
    vecs[5] = '{4'h2, 32'h300,   32'hFFFF_FFFC, 32'h0,        32'hDEAD_BEEF, 32'h2FC,   3'd4, 32'hDEAD_BEEF};
    vecs[6] = '{4'h0, 32'h204,   32'h1,        32'h0,         32'h1234_567F, 32'h205,   3'd1, 32'h0000_007F};
    vecs[7] = '{4'h8, 32'h104,   32'h0,        32'h0000_00AB, 32'h0,         32'h104,   3'd1, 32'h0};
    vecs[8] = '{4'h9, 32'h108,   32'h2,        32'h0000_BEEF, 32'h0,         32'h10A,   3'd2, 32'h0};
    vecs[9] = '{4'h1, 32'h2FFF0, 32'hC,        32'h0,         32'hFFFF_7FFF, 32'h2FFFC, 3'd2, 32'h0000_7FFF};

    rst = 1'b1; rdy = 1'b1; dsp_en = 0; dsp_vj = 0; dsp_vk = 0; dsp_imm = 0;
    dsp_qj = 0; dsp_qk = 0; dsp_rob_id = 0; dsp_type = 0; cdb_rs_en = 0;
    cdb_rs_id = 0; cdb_rs_val = 0; mem_ok = 0; mem_rdata = 0; commit_en = 0;
    commit_rob_id = 0; rob_head_id = 0; flush = 0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_cdb_en", {31'd0, cdb_lsb_en}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);

    // Single-op vectors: stores wait for commit, non-IO loads issue at once.
    for (int i = 0; i < NV; i++) begin
      logic [4:0] tag;
      logic       is_st;
      tag   = 5'(i + 1);
      is_st = vecs[i].op[3];
      dispatch(vecs[i].op, vecs[i].vj, vecs[i].vk, vecs[i].imm, 5'd0, tag);
      if (is_st) begin
        repeat (3) tick();
        check("st_wait_no_issue", {31'd0, mem_en}, 32'd0);
        commit_en = 1'b1; commit_rob_id = tag;
        tick();
        commit_en = 1'b0;
        check("st_commit_issue", {31'd0, mem_en}, 32'd1);
      end else begin
        wait_mem("ld");
      end
      check("vec_addr", mem_addr, vecs[i].exp_addr);
      check("vec_width", {29'd0, mem_width}, {29'd0, vecs[i].exp_width});
      check("vec_we", {31'd0, mem_we}, {31'd0, is_st});
      if (is_st) check("vec_wdata", mem_wdata, vecs[i].vk);
      complete(vecs[i].rdata);
      check("vec_mem_en_drop", {31'd0, mem_en}, 32'd0);
      check("vec_cdb_en", {31'd0, cdb_lsb_en}, {31'd0, !is_st});
      if (!is_st) begin
        check("vec_cdb_val", cdb_lsb_val, vecs[i].exp_val);
        check("vec_cdb_id", {27'd0, cdb_lsb_id}, {27'd0, tag});
      end
      $display("vector %0d op=%h addr=%h cdb=%h", i, vecs[i].op, mem_addr, cdb_lsb_val);
      tick();
      check("vec_cdb_pulse", {31'd0, cdb_lsb_en}, 32'd0);
    end

    // IO load waits for ROB head.
    dispatch(4'h2, 32'h30000, 32'h0, 32'h4, 5'd0, 5'd7);
    repeat (4) tick();
    check("io_wait", {31'd0, mem_en}, 32'd0);
    rob_head_id = 5'd7;
    tick();
    rob_head_id = 5'd0;
    check("io_issue", {31'd0, mem_en}, 32'd1);
    check("io_addr", mem_addr, 32'h30004);
    complete(32'hCAFE_F00D);
    check("io_cdb", cdb_lsb_val, 32'hCAFE_F00D);

    // Dispatch-time bypass from cdb_rs.
    cdb_rs_en = 1'b1; cdb_rs_id = 5'd3; cdb_rs_val = 32'h40;
    dispatch(4'h2, 32'h0, 32'h0, 32'h10, 5'd3, 5'd8);
    cdb_rs_en = 1'b0;
    wait_mem("byp");
    check("byp_addr", mem_addr, 32'h50);
    complete(32'h1);
    check("byp_cdb_id", {27'd0, cdb_lsb_id}, 32'd8);

    // Wakeup of a queued entry.
    dispatch(4'h2, 32'h0, 32'h0, 32'h8, 5'd4, 5'd9);
    repeat (3) tick();
    check("wake_wait", {31'd0, mem_en}, 32'd0);
    cdb_rs_en = 1'b1; cdb_rs_id = 5'd4; cdb_rs_val = 32'h60;
    tick();
    cdb_rs_en = 1'b0;
    wait_mem("wake");
    check("wake_addr", mem_addr, 32'h68);
    complete(32'h2);

    // Fill to LSB_DEPTH-1; pointers wrap past index 15.
    for (int k = 0; k < 15; k++) begin
      dispatch(4'hA, 32'h1000, 32'(k), 32'(4 * k), 5'd0, 5'(k + 1));
      if (k == 13) check("full_at_14", {31'd0, full}, 32'd0);
    end
    check("full_at_15", {31'd0, full}, 32'd1);
    for (int k = 0; k < 15; k++) begin
      commit_en = 1'b1; commit_rob_id = 5'(k + 1);
      tick();
      commit_en = 1'b0;
      check("wrap_issue", {31'd0, mem_en}, 32'd1);
      check("wrap_addr", mem_addr, 32'h1000 + 32'(4 * k));
      check("wrap_wdata", mem_wdata, 32'(k));
      complete(32'h0);
      if (k == 0) check("full_after_pop", {31'd0, full}, 32'd0);
    end

    // Flush while a speculative LW is in MEM with two committed SW behind it.
    dispatch(4'h2, 32'h400, 32'h0, 32'h0, 5'd0, 5'd20);
    dispatch(4'hA, 32'h600, 32'h11, 32'h0, 5'd0, 5'd21);
    dispatch(4'hA, 32'h604, 32'h22, 32'h0, 5'd0, 5'd22);
    commit_en = 1'b1; commit_rob_id = 5'd21;
    tick();
    commit_rob_id = 5'd22;
    tick();
    commit_en = 1'b0;
    check("fl_ld_in_mem", {31'd0, mem_en}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_count", {27'd0, dut.count_q}, 32'd2);
    check("fl_drain_hold", {31'd0, mem_en}, 32'd1);
    check("fl_drain_addr", mem_addr, 32'h400);
    complete(32'h55);
    check("fl_no_cdb", {31'd0, cdb_lsb_en}, 32'd0);
    check("fl_drain_done", {31'd0, mem_en}, 32'd0);
    tick();
    check("fl_no_cdb2", {31'd0, cdb_lsb_en}, 32'd0);
    wait_mem("fl_st1");
    check("fl_st1_addr", mem_addr, 32'h600);
    check("fl_st1_wdata", mem_wdata, 32'h11);
    complete(32'h0);
    wait_mem("fl_st2");
    check("fl_st2_addr", mem_addr, 32'h604);
    check("fl_st2_we", {31'd0, mem_we}, 32'd1);
    complete(32'h0);
    repeat (3) tick();
    check("fl_empty", {27'd0, dut.count_q}, 32'd0);
    check("fl_idle", {31'd0, mem_en}, 32'd0);

    // Flush of an uncommitted store in WAIT: it never issues.
    dispatch(4'hA, 32'h700, 32'h77, 32'h0, 5'd0, 5'd25);
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    commit_en = 1'b1; commit_rob_id = 5'd25;
    tick();
    commit_en = 1'b0;
    repeat (2) tick();
    check("flw_no_issue", {31'd0, mem_en}, 32'd0);
    check("flw_count", {27'd0, dut.count_q}, 32'd0);

    // rdy low freezes a request; reset aborts it asynchronously.
    dispatch(4'h2, 32'h500, 32'h0, 32'h0, 5'd0, 5'd26);
    wait_mem("rst_ld");
    rdy = 1'b0; mem_ok = 1'b1;
    repeat (2) tick();
    check("rdy_hold", {31'd0, mem_en}, 32'd1);
    check("rdy_no_cdb", {31'd0, cdb_lsb_en}, 32'd0);
    mem_ok = 1'b0; rdy = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("async_rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("async_rst_count", {27'd0, dut.count_q}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    check("post_rst_mem_en", {31'd0, mem_en}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsb_queue.md
Name: lsb_queue

Overview:
- Parametrised load/store buffer sitting between Dispatcher, CDB, ROB and memctrl; next generation of the core's single-port load/store unit.
- Circular queue of LSB_DEPTH entries; issues memory ops in program order from the head.
- New over the previous generation: speculative loads to non-IO addresses issue without waiting for ROB; IO loads wait for ROB head; a flush drains any in-flight speculative load cleanly.

Parameters:
LSB_DEPTH, 16, entry count; power of 2, >=4
ROB_ID_W, 5, ROB tag width; tag 0 = NON_DEPENDENT
XLEN, 32, data/address width
IO_BASE, 32'h0003_0000, addresses >= IO_BASE are IO (non-speculative)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rdy  in  1  global enable; when low all state holds
dsp_en  in  1  enqueue one entry this cycle
dsp_vj, dsp_vk, dsp_imm  in  XLEN  base, store data, offset
dsp_qj, dsp_qk, dsp_rob_id  in  ROB_ID_W  operand tags, own tag
dsp_type  in  4  LB/LH/LW/LBU/LHU/SB/SH/SW code from shared package
cdb_rs_en, cdb_rs_id, cdb_rs_val  in  1/ROB_ID_W/XLEN  ALU broadcast
cdb_lsb_en, cdb_lsb_id, cdb_lsb_val  out  1/ROB_ID_W/XLEN  load-result broadcast
mem_en, mem_we  out  1  request valid; 0 read 1 write
mem_addr, mem_wdata  out  XLEN
mem_width  out  3  bytes: 1, 2 or 4
mem_ok, mem_rdata  in  1/XLEN  completion pulse, read data
commit_en, commit_rob_id  in  1/ROB_ID_W  ROB commit
rob_head_id  in  ROB_ID_W  oldest uncommitted ROB tag
flush  in  1  mispredict
full  out  1  no room for another dispatch

Behaviour:
- Reset: head=tail=count=0, all busy/committed=0, state IDLE, mem_en=0, cdb_lsb_en=0, all other outputs 0.
- full = (count >= LSB_DEPTH-1); one-slot margin for the registered dispatch path. Pointers wrap modulo LSB_DEPTH; count is clog2(LSB_DEPTH)+1 bits.
- Enqueue: operands bypassed from cdb_rs and own cdb_lsb in the same cycle. A CDB tag match clears Q and captures V; cdb_rs takes priority.
- Wakeup: every busy entry with Qj/Qk matching a CDB tag (tag != 0) captures the value into Vj/Vk respectively.
- commit_en marks the matching busy entry committed; committed_tail advances once per newly committed entry.
- addr = Vj + imm, computed at head.
- FSM:
  - IDLE: head busy and ready.
    - Store: goes to MEM if committed, else WAIT.
    - Load with addr < IO_BASE: goes to MEM immediately.
    - Load with addr >= IO_BASE: goes to MEM when rob_head_id == entry tag, else WAIT.
  - WAIT: re-evaluates the same condition each cycle; enters MEM with mem_en=1 the cycle after it is met.
  - MEM: hold mem_en and all request fields stable until mem_ok.
    - On mem_ok: mem_en=0, pop head, back to IDLE.
    - Load on mem_ok: cdb_lsb_en=1 for exactly 1 cycle with rob tag and extended data. LB/LH sign-extend bits 7/15; LBU/LHU zero-extend.
  - DRAIN: entered on flush while a load is in MEM. Keep mem_en=1 until mem_ok, discard data (no CDB), return to IDLE.
- Flush:
  - tail <- committed_tail; uncommitted entries cleared; count recomputed.
  - cdb_lsb_en <- 0.
  - Committed stores survive, and a committed store in MEM continues.
  - An uncommitted load in WAIT returns to IDLE.
- Simultaneous dispatch and pop: count unchanged.
- Flush has priority over dispatch and commit in the same cycle.
- Reset mid-transaction aborts immediately: mem_en low asynchronously.

Optional Feature:
LSB_PERF_CNT_EN.
- Defined: adds 32-bit outputs perf_loads, perf_stores and perf_wait_cycles.
  - perf_loads and perf_stores increment on each completed load/store mem_ok (drained loads not counted).
  - perf_wait_cycles increments each cycle in WAIT.
  - All saturate at all-ones; reset 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package: op-type codes, NON_DEPENDENT=0, XLEN, IO_BASE, width-code mapping.
- One sub-module: lsb_load_ext, combinational load extension (type, raw data -> XLEN result).

Test Plan:
1. SW x=0x1234_5678 to 0x100, uncommitted -> stays in WAIT, mem_en=0. commit_en with its tag -> next cycle mem_en=1, we=1, width=4; on mem_ok -> head advances.
2. LB from 0x200, memory byte 0x80, operands ready -> mem_en issued without commit; cdb_lsb_val=0xFFFF_FF80. Same stimulus with LBU -> 0x0000_0080.
3. LW from 0x30004 -> waits until rob_head_id equals its tag, then issues.
4. Dispatch with Qj=3 while cdb_rs_id=3, val=0x40 -> entry captures Vj=0x40, Qj=0, and issues at addr 0x40+imm.
5. Fill to LSB_DEPTH-1 entries -> full=1. Pop one -> full=0. Pointers wrap past index 15 without loss.
6. flush while uncommitted LW in MEM with 2 committed SW queued -> no CDB pulse; mem_en held until mem_ok; both stores then complete; count=2 after flush.
